// File: rtl/pll_reset_seq_pkg.sv
// rtl/pll_reset_seq_pkg.sv - state encodings, default timing and sizing helpers for the PLL reset sequencer
package pll_reset_seq_pkg;

  typedef enum logic [1:0] {
    S_PRST = 2'd0,
    S_WAIT = 2'd1,
    S_REL  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam int DEF_RST_CYC     = 16;
  localparam int DEF_STABLE_CYC  = 1024;
  localparam int DEF_TIMEOUT_CYC = 65536;
  localparam int DEF_NSTAGE      = 3;
  localparam int DEF_STAGE_GAP   = 32;
  localparam int DEF_CNT_W       = 8;

  // Width of the shared cycle counter: enough for the longest interval, never zero.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with asynchronous active-low reset to 0
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset pulse, lock qualification and staged domain reset release
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int RST_CYC     = DEF_RST_CYC,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int NSTAGE      = DEF_NSTAGE,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              relock_req,
  output logic              pll_rst,
  output logic [NSTAGE-1:0] dom_rst_n,
  output logic              ready,
  output logic [CNT_W-1:0]  lost_cnt,
  output logic [CNT_W-1:0]  tmo_cnt
);

  localparam int CW = cnt_width(RST_CYC, STABLE_CYC, TIMEOUT_CYC, NSTAGE * STAGE_GAP);
  localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     stb_q, stb_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              pll_rst_d, ready_d;
  logic [NSTAGE-1:0] dom_d;
  logic [CNT_W-1:0]  lost_d, tmo_d;
  logic              lk_s;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lk_s)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PRST;
      cnt_q     <= '0;
      stb_q     <= '0;
      idx_q     <= '0;
      pll_rst   <= 1'b1;
      dom_rst_n <= '0;
      ready     <= 1'b0;
      lost_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stb_q     <= stb_d;
      idx_q     <= idx_d;
      pll_rst   <= pll_rst_d;
      dom_rst_n <= dom_d;
      ready     <= ready_d;
      lost_cnt  <= lost_d;
      tmo_cnt   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    stb_d     = stb_q;
    idx_d     = idx_q;
    pll_rst_d = pll_rst;
    dom_d     = dom_rst_n;
    ready_d   = ready;
    lost_d    = lost_cnt;
    tmo_d     = tmo_cnt;
    case (state_q)
      S_PRST: begin
        pll_rst_d = 1'b1;
        dom_d     = '0;
        ready_d   = 1'b0;
        if (cnt_q == CW'(RST_CYC - 1)) begin
          state_d   = S_WAIT;
          cnt_d     = '0;
          stb_d     = '0;
          pll_rst_d = 1'b0;
        end
      end
      S_WAIT: begin
        stb_d = lk_s ? stb_q + 1'b1 : '0;
        // Qualification is tested first so it wins a tie with the timeout.
        if (lk_s && stb_q == CW'(STABLE_CYC - 1)) begin
          state_d = (NSTAGE == 1) ? S_RUN : S_REL;
          ready_d = (NSTAGE == 1);
          cnt_d   = '0;
          dom_d   = NSTAGE'(1);
          idx_d   = IW'(1);
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d   = S_PRST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          tmo_d     = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
        end
      end
      S_REL, S_RUN: begin
        if (state_q == S_RUN) cnt_d = cnt_q;
        if (!lk_s) begin
          state_d   = S_PRST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          dom_d     = '0;
          ready_d   = 1'b0;
          lost_d    = (lost_cnt == '1) ? lost_cnt : lost_cnt + 1'b1;
        end else if (state_q == S_RUN) begin
          if (relock_req) begin
            state_d   = S_PRST;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            dom_d     = '0;
            ready_d   = 1'b0;
          end
        end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
          cnt_d = '0;
          dom_d = dom_rst_n | (NSTAGE'(1) << idx_q);
          if (idx_q == IW'(NSTAGE - 1)) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_PRST;
    endcase
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - directed self-checking bench for pll_reset_seq
module tb_pll_reset_seq;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic [2:0] dom_rst_n;
  logic       ready;
  logic [7:0] lost_cnt;
  logic [7:0] tmo_cnt;

  int checks = 0;
  int fails  = 0;

  pll_reset_seq #(
    .RST_CYC(4), .STABLE_CYC(8), .TIMEOUT_CYC(40),
    .NSTAGE(3), .STAGE_GAP(5), .CNT_W(8)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .locked     (locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .dom_rst_n  (dom_rst_n),
    .ready      (ready),
    .lost_cnt   (lost_cnt),
    .tmo_cnt    (tmo_cnt)
  );

  always #10 clkin = ~clkin;

  task automatic do_reset();
    rst_n = 1'b0;
    relock_req = 1'b0;
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;
  endtask

  task automatic wait_dom(input logic [2:0] v, output int n);
    n = 0;
    while (dom_rst_n !== v && n < 500) begin
      @(negedge clkin);
      n++;
    end
  endtask

  task automatic wait_pll(input logic v, output int n);
    n = 0;
    while (pll_rst !== v && n < 500) begin
      @(negedge clkin);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clkin);
    checks++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    checks++; if (dom_rst_n !== 3'b000) begin fails++; $display("FAIL reset_dom: got %b want 000", dom_rst_n); end
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (lost_cnt !== 8'd0 || tmo_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", lost_cnt, tmo_cnt); end
  endtask

  task automatic test_powerup();
    int n;
    locked = 1'b1;
    do_reset();
    wait_pll(1'b0, n);
    checks++; if (n != 4) begin fails++; $display("FAIL powerup_pll_pulse: got %0d want 4", n); end
    wait_dom(3'b001, n);
    checks++; if (n != 8) begin fails++; $display("FAIL powerup_stage0: got %0d want 8", n); end
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL powerup_ready_early: got %b want 0", ready); end
    wait_dom(3'b011, n);
    checks++; if (n != 5) begin fails++; $display("FAIL powerup_stage1: got %0d want 5", n); end
    wait_dom(3'b111, n);
    checks++; if (n != 5) begin fails++; $display("FAIL powerup_stage2: got %0d want 5", n); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL powerup_ready: got %b want 1", ready); end
    checks++; if (lost_cnt !== 8'd0 || tmo_cnt !== 8'd0) begin fails++; $display("FAIL powerup_cnts: got %0d/%0d want 0/0", lost_cnt, tmo_cnt); end
  endtask

  task automatic test_glitch();
    int n;
    locked = 1'b1;
    do_reset();
    wait_pll(1'b0, n);
    repeat (4) @(negedge clkin);
    locked = 1'b0;
    @(negedge clkin);
    locked = 1'b1;
    wait_dom(3'b001, n);
    checks++; if (n != 10) begin fails++; $display("FAIL glitch_release: got %0d want 10", n); end
  endtask

  task automatic test_timeout();
    int n;
    locked = 1'b0;
    do_reset();
    for (int p = 1; p <= 2; p++) begin
      wait_pll(1'b0, n);
      checks++; if (n != 4) begin fails++; $display("FAIL timeout_pulse%0d: got %0d want 4", p, n); end
      wait_pll(1'b1, n);
      checks++; if (n != 40) begin fails++; $display("FAIL timeout_wait%0d: got %0d want 40", p, n); end
      checks++; if (tmo_cnt !== 8'(p)) begin fails++; $display("FAIL timeout_cnt%0d: got %0d want %0d", p, tmo_cnt, p); end
      checks++; if (dom_rst_n !== 3'b000) begin fails++; $display("FAIL timeout_dom%0d: got %b want 000", p, dom_rst_n); end
    end
  endtask

  task automatic test_loss_run();
    int n;
    locked = 1'b1;
    do_reset();
    wait_dom(3'b111, n);
    locked = 1'b0;
    repeat (2) @(negedge clkin);
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL loss_ready_hold: got %b want 1", ready); end
    @(negedge clkin);
    checks++; if (dom_rst_n !== 3'b000 || ready !== 1'b0 || pll_rst !== 1'b1) begin
      fails++; $display("FAIL loss_outputs: got dom=%b ready=%b pll_rst=%b want 000/0/1", dom_rst_n, ready, pll_rst);
    end
    checks++; if (lost_cnt !== 8'd1) begin fails++; $display("FAIL loss_cnt: got %0d want 1", lost_cnt); end
    locked = 1'b1;
    wait_dom(3'b111, n);
    checks++; if (n != 22 || ready !== 1'b1) begin fails++; $display("FAIL loss_reseq: got %0d cycles ready=%b want 22/1", n, ready); end
  endtask

  task automatic test_relock();
    int n;
    locked = 1'b0;
    repeat (2) @(negedge clkin);
    relock_req = 1'b1;
    @(negedge clkin);
    relock_req = 1'b0;
    checks++; if (lost_cnt !== 8'd2 || pll_rst !== 1'b1) begin fails++; $display("FAIL relock_loss: got lost=%0d pll_rst=%b want 2/1", lost_cnt, pll_rst); end
    wait_pll(1'b0, n);
    checks++; if (n != 4) begin fails++; $display("FAIL relock_loss_pulse: got %0d want 4", n); end
    repeat (6) @(negedge clkin);
    relock_req = 1'b1;
    @(negedge clkin);
    relock_req = 1'b0;
    @(negedge clkin);
    checks++; if (pll_rst !== 1'b0 || lost_cnt !== 8'd2) begin fails++; $display("FAIL relock_ignored: got pll_rst=%b lost=%0d want 0/2", pll_rst, lost_cnt); end
    locked = 1'b1;
    wait_dom(3'b111, n);
    relock_req = 1'b1;
    @(negedge clkin);
    relock_req = 1'b0;
    checks++; if (pll_rst !== 1'b1 || ready !== 1'b0 || dom_rst_n !== 3'b000 || lost_cnt !== 8'd2) begin
      fails++; $display("FAIL relock_run: got pll_rst=%b ready=%b dom=%b lost=%0d want 1/0/000/2", pll_rst, ready, dom_rst_n, lost_cnt);
    end
  endtask

  task automatic test_reset_mid_rel();
    int n;
    wait_dom(3'b011, n);
    checks++; if (dom_rst_n !== 3'b011) begin fails++; $display("FAIL midrel_reach: got %b want 011", dom_rst_n); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1 || dom_rst_n !== 3'b000 || ready !== 1'b0) begin
      fails++; $display("FAIL midrel_outputs: got pll_rst=%b dom=%b ready=%b want 1/000/0", pll_rst, dom_rst_n, ready);
    end
    checks++; if (lost_cnt !== 8'd0 || tmo_cnt !== 8'd0) begin fails++; $display("FAIL midrel_cnts: got %0d/%0d want 0/0", lost_cnt, tmo_cnt); end
    @(negedge clkin);
  endtask

  task automatic test_saturation();
    int n;
    int tout;
    tout = 0;
    locked = 1'b1;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      wait_dom(3'b001, n);
      if (n >= 500) tout++;
      locked = 1'b0;
      wait_pll(1'b1, n);
      if (n >= 500) tout++;
      locked = 1'b1;
      if (i == 0) begin
        checks++; if (lost_cnt !== 8'd1) begin fails++; $display("FAIL sat_first: got %0d want 1", lost_cnt); end
      end
      if (i == 254) begin
        checks++; if (lost_cnt !== 8'hFF) begin fails++; $display("FAIL sat_255: got %0d want 255", lost_cnt); end
      end
    end
    checks++; if (lost_cnt !== 8'hFF) begin fails++; $display("FAIL sat_hold: got %0d want 255", lost_cnt); end
    checks++; if (tout != 0) begin fails++; $display("FAIL sat_timeouts: got %0d want 0", tout); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_glitch();
    test_timeout();
    test_loss_run();
    test_relock();
    test_reset_mid_rel();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
